fetch_stage_ctrl: RTL and testbench
===================================

FETCH_STAGE_CTRL -- requirements
Module: fetch_stage_ctrl

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 Rst  input  1  asynchronous, active-low reset; Rst=0 forces reset state immediately, independent of Clk.
REQ-003 Stall  input  1  hazard hold from decode; 1 = IF/ID must not accept a new instruction.
REQ-004 BranchTaken  input  1  one-cycle redirect pulse from EX.
REQ-005 BranchTarget  input  32  redirect address, sampled when BranchTaken=1.
REQ-006 IMemReq  output  1  instruction-memory read request.
REQ-007 IMemAddr  output  32  word address of the current request.
REQ-008 IMemReady  input  1  memory completes the request this cycle; IMemRData valid.
REQ-009 IMemRData  input  32  instruction word returned by memory.
REQ-010 Instruction  output  32  fetched instruction presented to IF/ID.
REQ-011 InstrValid  output  1  Instruction/PCAddResult valid this cycle.
REQ-012 PCValue  output  32  current fetch PC.
REQ-013 PCAddResult  output  32  address of presented instruction + 4.
REQ-014 Flush  output  1  one-cycle pulse telling IF/ID to squash its contents.
REQ-015 FetchStallCount  output  32  present only when FETCH_PERF_CNT_EN is defined (REQ-033).

Function
REQ-016 FSM states SHALL be REQ, WAIT, HOLD, DRAIN.
REQ-017 REQ/WAIT: IMemReq=1, IMemAddr=PCValue; request and address SHALL stay constant until the cycle IMemReady=1.
REQ-018 REQ->WAIT when IMemReady=0; REQ/WAIT complete on IMemReady=1.
REQ-019 On completion without redirect or Stall: capture IMemRData into Instruction, PCAddResult<=PCValue+4, PCValue<=PCValue+4, InstrValid=1 next cycle, remain in REQ (back-to-back fetch).
REQ-020 Zero-wait memory (IMemReady=1 in REQ cycle) SHALL yield one instruction per cycle, latency 1 cycle request-to-InstrValid.
REQ-021 On completion with Stall=1: capture instruction, set InstrValid=1, hold PCValue, enter HOLD; IMemReq=0 in HOLD.
REQ-022 HOLD: Instruction, PCAddResult, InstrValid SHALL remain constant; when Stall=0, PCValue<=PCValue+4 and enter REQ.
REQ-023 InstrValid SHALL deassert the cycle after a consumed instruction when no new completion occurs; Instruction SHALL then read 0x00000000 (NOP).
REQ-024 BranchTaken=1 SHALL take priority over Stall and completion: PCValue<=BranchTarget, Flush=1 next cycle for exactly one cycle, InstrValid<=0.
REQ-025 BranchTaken=1 while a request is outstanding and IMemReady=0: enter DRAIN, keep IMemReq/IMemAddr at the old address until IMemReady=1, discard the returned word, then REQ at the new PC.
REQ-026 BranchTaken=1 in the same cycle as IMemReady=1: discard IMemRData, go directly to REQ at BranchTarget.
REQ-027 BranchTaken in DRAIN SHALL overwrite the pending target (last redirect wins).
REQ-028 BranchTarget[1:0] SHALL be ignored (forced 00); PC arithmetic wraps modulo 2^32 (0xFFFFFFFC+4=0x00000000).

Reset
REQ-029 Rst=0 SHALL set state=REQ, PCValue=0x00000000, Instruction=0, PCAddResult=0, InstrValid=0, Flush=0, IMemReq=0, FetchStallCount=0.
REQ-030 IMemReq SHALL first assert in the first cycle after Rst deasserts.
REQ-031 Reset mid-request SHALL abandon the request; any later IMemReady for it is ignored (memory is reset on the same Rst).
REQ-032 Reset deassertion SHALL be synchronised by the integrator; block assumes clean release.

Configuration
REQ-033 FETCH_PERF_CNT_EN defined: FetchStallCount increments (saturating at 0xFFFFFFFF) every cycle in WAIT, HOLD or DRAIN; undefined: port and counter absent, behaviour otherwise identical.

Verification
REQ-034 Rst release, zero-wait memory returning 0x20080001,0x20090002 -> InstrValid from cycle 2, PCAddResult 4 then 8, PCValue 8 after two fetches.
REQ-035 IMemReady delayed 3 cycles at PC=0x10 -> IMemAddr held 0x10 for 4 cycles, InstrValid one cycle after ready, count +3 (with EN).
REQ-036 Stall=1 for 2 cycles on completion at PC=0x20 -> Instruction/PCAddResult=0x24 held 3 cycles, IMemReq=0, then fetch 0x24.
REQ-037 BranchTaken=1, target 0x40, during WAIT at 0x08 -> DRAIN, old word discarded, Flush one cycle, next IMemAddr 0x40.
REQ-038 BranchTaken and Stall both 1, target 0x103 -> PCValue 0x100, Flush=1, InstrValid=0.
REQ-039 Rst=0 asserted during WAIT -> all outputs at reset values same cycle without a clock edge.

Source files
------------

// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch stage controller: PC sequencing, memory handshake, stall hold, branch redirect.
// Optional stall-cycle counter is built when FETCH_PERF_CNT_EN is defined.
module fetch_stage_ctrl (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemRData,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  output logic [31:0] PCValue,
  output logic [31:0] PCAddResult,
  output logic        Flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchStallCount
`endif
);

  localparam logic [1:0] StReq   = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_add_q, pc_add_d;
  logic        valid_q, valid_d;
  logic        flush_q, flush_d;
  logic [31:0] pc_inc;
  logic [31:0] target_aligned;

  assign pc_inc         = pc_q + 32'd4;
  assign target_aligned = {BranchTarget[31:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    pc_add_d     = pc_add_q;
    valid_d      = valid_q;
    flush_d      = BranchTaken;

    if (BranchTaken) begin
      // Redirect wins over stall and completion; PC already holds the new target while draining.
      pc_d    = target_aligned;
      valid_d = 1'b0;
      instr_d = 32'h0;
      unique case (state_q)
        StReq, StWait: begin
          if (IMemReady) begin
            state_d = StReq;
          end else begin
            state_d      = StDrain;
            drain_addr_d = pc_q;
          end
        end
        StHold:  state_d = StReq;
        StDrain: state_d = IMemReady ? StReq : StDrain;
        default: state_d = StReq;
      endcase
    end else begin
      unique case (state_q)
        StReq, StWait: begin
          if (IMemReady) begin
            instr_d  = IMemRData;
            pc_add_d = pc_inc;
            valid_d  = 1'b1;
            if (Stall) begin
              state_d = StHold;
            end else begin
              pc_d    = pc_inc;
              state_d = StReq;
            end
          end else begin
            state_d = StWait;
            valid_d = 1'b0;
            instr_d = 32'h0;
          end
        end
        StHold: begin
          if (!Stall) begin
            pc_d    = pc_inc;
            state_d = StReq;
            valid_d = 1'b0;
            instr_d = 32'h0;
          end
        end
        StDrain: begin
          valid_d = 1'b0;
          instr_d = 32'h0;
          if (IMemReady) state_d = StReq;
        end
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= StReq;
      pc_q         <= 32'h0;
      drain_addr_q <= 32'h0;
      instr_q      <= 32'h0;
      pc_add_q     <= 32'h0;
      valid_q      <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      pc_add_q     <= pc_add_d;
      valid_q      <= valid_d;
      flush_q      <= flush_d;
    end
  end

  // Gated by Rst so the request drops in the same cycle reset is asserted.
  assign IMemReq     = Rst & (state_q != StHold);
  assign IMemAddr    = (state_q == StDrain) ? drain_addr_q : pc_q;
  assign Instruction = instr_q;
  assign InstrValid  = valid_q;
  assign PCValue     = pc_q;
  assign PCAddResult = pc_add_q;
  assign Flush       = flush_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != StReq) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FetchStallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed table-driven bench for fetch_stage_ctrl plus hand-written reset sequences.
module tb_fetch_stage_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemRData;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic [31:0] PCValue;
  logic [31:0] PCAddResult;
  logic        Flush;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchStallCount;
`endif

  fetch_stage_ctrl dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemReady    (IMemReady),
    .IMemRData    (IMemRData),
    .Instruction  (Instruction),
    .InstrValid   (InstrValid),
    .PCValue      (PCValue),
    .PCAddResult  (PCAddResult),
    .Flush        (Flush)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchStallCount (FetchStallCount)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pcadd;
    logic        e_flush;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic br, input logic [31:0] tgt, input logic rdy,
                     input logic [31:0] rd, input logic req, input logic [31:0] addr,
                     input logic vl, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [31:0] pca, input logic fl, input logic [31:0] cnt);
    vec_t v;
    v.stall = st; v.br = br; v.tgt = tgt; v.rdy = rdy; v.rdata = rd;
    v.e_req = req; v.e_addr = addr; v.e_valid = vl; v.e_instr = ins;
    v.e_pc = pc; v.e_pcadd = pca; v.e_flush = fl; v.e_cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic req, input logic [31:0] addr,
                               input logic vl, input logic [31:0] ins, input logic [31:0] pc,
                               input logic [31:0] pca, input logic fl);
    chk({tag, ".IMemReq"},     {31'h0, IMemReq},    {31'h0, req});
    chk({tag, ".IMemAddr"},    IMemAddr,            addr);
    chk({tag, ".InstrValid"},  {31'h0, InstrValid}, {31'h0, vl});
    chk({tag, ".Instruction"}, Instruction,         ins);
    chk({tag, ".PCValue"},     PCValue,             pc);
    chk({tag, ".PCAddResult"}, PCAddResult,         pca);
    chk({tag, ".Flush"},       {31'h0, Flush},      {31'h0, fl});
  endtask

  initial begin
    // Each row: inputs driven this cycle, outputs expected this cycle (before the consuming edge).
    //  st br tgt            rdy rdata          req addr          vl instr          pc             pcadd          fl cnt
    add(0, 0, 32'h0,         1, 32'h20080001, 1, 32'h00000000, 0, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0);
    add(0, 0, 32'h0,         1, 32'h20090002, 1, 32'h00000004, 1, 32'h20080001, 32'h00000004, 32'h00000004, 0, 0);
    add(0, 0, 32'h0,         0, 32'h0,        1, 32'h00000008, 1, 32'h20090002, 32'h00000008, 32'h00000008, 0, 0);
    add(0, 1, 32'h40,        0, 32'h0,        1, 32'h00000008, 0, 32'h00000000, 32'h00000008, 32'h00000008, 0, 0);
    add(0, 0, 32'h0,         1, 32'hDEADBEEF, 1, 32'h00000008, 0, 32'h00000000, 32'h00000040, 32'h00000008, 1, 1);
    add(0, 0, 32'h0,         0, 32'h0,        1, 32'h00000040, 0, 32'h00000000, 32'h00000040, 32'h00000008, 0, 2);
    add(0, 0, 32'h0,         0, 32'h0,        1, 32'h00000040, 0, 32'h00000000, 32'h00000040, 32'h00000008, 0, 2);
    add(0, 0, 32'h0,         0, 32'h0,        1, 32'h00000040, 0, 32'h00000000, 32'h00000040, 32'h00000008, 0, 3);
    add(1, 0, 32'h0,         1, 32'h11111111, 1, 32'h00000040, 0, 32'h00000000, 32'h00000040, 32'h00000008, 0, 4);
    add(1, 0, 32'h0,         0, 32'h0,        0, 32'h00000040, 1, 32'h11111111, 32'h00000040, 32'h00000044, 0, 5);
    add(0, 0, 32'h0,         0, 32'h0,        0, 32'h00000040, 1, 32'h11111111, 32'h00000040, 32'h00000044, 0, 6);
    add(1, 1, 32'h103,       1, 32'h22222222, 1, 32'h00000044, 0, 32'h00000000, 32'h00000044, 32'h00000044, 0, 7);
    add(0, 0, 32'h0,         1, 32'h33333333, 1, 32'h00000100, 0, 32'h00000000, 32'h00000100, 32'h00000044, 1, 7);
    add(0, 1, 32'hFFFFFFFC,  0, 32'h0,        1, 32'h00000104, 1, 32'h33333333, 32'h00000104, 32'h00000104, 0, 7);
    add(0, 1, 32'h200,       0, 32'h0,        1, 32'h00000104, 0, 32'h00000000, 32'hFFFFFFFC, 32'h00000104, 1, 7);
    add(0, 1, 32'hFFFFFFFD,  1, 32'hBADBAD00, 1, 32'h00000104, 0, 32'h00000000, 32'h00000200, 32'h00000104, 1, 8);
    add(0, 0, 32'h0,         1, 32'h44444444, 1, 32'hFFFFFFFC, 0, 32'h00000000, 32'hFFFFFFFC, 32'h00000104, 1, 9);
    add(0, 0, 32'h0,         0, 32'h0,        1, 32'h00000000, 1, 32'h44444444, 32'h00000000, 32'h00000000, 0, 9);
    add(0, 0, 32'h0,         0, 32'h0,        1, 32'h00000000, 0, 32'h00000000, 32'h00000000, 32'h00000000, 0, 9);
    add(0, 0, 32'h0,         1, 32'h55555555, 1, 32'h00000000, 0, 32'h00000000, 32'h00000000, 32'h00000000, 0, 10);
    add(0, 0, 32'h0,         0, 32'h0,        1, 32'h00000004, 1, 32'h55555555, 32'h00000004, 32'h00000004, 0, 11);
    add(0, 0, 32'h0,         0, 32'h0,        1, 32'h00000004, 0, 32'h00000000, 32'h00000004, 32'h00000004, 0, 11);

    Rst = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
    IMemReady = 1'b0; IMemRData = 32'h0;
    repeat (2) @(posedge Clk);
    #1;
    check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("reset.FetchStallCount", FetchStallCount, 32'h0);
`endif
    @(negedge Clk);
    Rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      Stall        = vq[i].stall;
      BranchTaken  = vq[i].br;
      BranchTarget = vq[i].tgt;
      IMemReady    = vq[i].rdy;
      IMemRData    = vq[i].rdata;
      #1;
      check_outputs($sformatf("row%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_valid,
                    vq[i].e_instr, vq[i].e_pc, vq[i].e_pcadd, vq[i].e_flush);
`ifdef FETCH_PERF_CNT_EN
      chk($sformatf("row%0d.FetchStallCount", i), FetchStallCount, vq[i].e_cnt);
`endif
      @(negedge Clk);
    end

    // Asynchronous reset in the middle of a WAIT, no clock edge in between.
    Stall = 1'b0; BranchTaken = 1'b0; IMemReady = 1'b0;
    #1;
    chk("prereset.PCValue", PCValue, 32'h4);
    #1;
    Rst = 1'b0;
    #1;
    check_outputs("async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("async_reset.FetchStallCount", FetchStallCount, 32'h0);
`endif
    // A late ready for the abandoned request must be ignored while in reset.
    IMemReady = 1'b1; IMemRData = 32'hCAFEF00D;
    @(posedge Clk);
    #1;
    check_outputs("held_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    @(negedge Clk);
    Rst = 1'b1; IMemReady = 1'b1; IMemRData = 32'h66666666;
    #1;
    check_outputs("release", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge Clk);
    IMemReady = 1'b0;
    #1;
    check_outputs("after_release", 1'b1, 32'h4, 1'b1, 32'h66666666, 32'h4, 32'h4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
